// File: rtl/serial_adder_pkg.sv
// serial_adder shared package: state encoding and WIDTH limits.
// Optional subtract mode is enabled by macro SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// fa_cell: combinational 1-bit full adder used by serial_adder.
// Optional subtract mode (SERIAL_ADDER_SUB_EN) does not affect this cell.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB first, start/done handshake.
// Define SERIAL_ADDER_SUB_EN to add the sub input and ovf output.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
  output logic             ovf,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CNT_W = $clog2(WIDTH);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_adder: WIDTH out of range");
  end

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-2:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_c;
  logic             r_cout;
  logic [CNT_W-1:0] r_cnt;
  logic             w_s;
  logic             w_co;
  logic             w_run;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_acc_nx;
  logic [WIDTH-1:0] w_b_ld;
  logic             w_c_ld;

  assign w_run    = (r_state == S_RUN);
  assign w_last   = w_run && (r_cnt == CNT_W'(WIDTH - 1));
  assign w_accept = start &&
                    ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_acc_nx = {w_s, r_acc};

  // Subtract is a + ~b + 1, so only the B load and carry seed differ.
`ifdef SERIAL_ADDER_SUB_EN
  logic r_ovf;
  assign w_b_ld = sub ? ~b : b;
  assign w_c_ld = sub ? 1'b1 : carry_in;
  assign ovf    = r_ovf;
`else
  assign w_b_ld = b;
  assign w_c_ld = carry_in;
`endif

  fa_cell u_fa (
    .x  (r_a_sh[0]),
    .y  (r_b_sh[0]),
    .ci (r_c),
    .s  (w_s),
    .co (w_co)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_acc  <= '0;
      r_c    <= 1'b0;
      r_cnt  <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      r_ovf  <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a_sh <= a;
      r_b_sh <= w_b_ld;
      r_c    <= w_c_ld;
      r_cnt  <= '0;
    end else if (w_run) begin
      r_a_sh <= r_a_sh >> 1;
      r_b_sh <= r_b_sh >> 1;
      r_c    <= w_co;
      r_acc  <= w_acc_nx[WIDTH-1:1];
      r_cnt  <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_sum  <= w_acc_nx;
        r_cout <= w_co;
`ifdef SERIAL_ADDER_SUB_EN
        r_ovf  <= r_c ^ w_co;
`endif
      end
    end
  end

  assign busy      = w_run;
  assign done      = (r_state == S_DONE);
  assign sum       = r_sum;
  assign carry_out = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: vector table, corner sequences and random ops vs model.
// Subtract checks are compiled in when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;
`ifdef SERIAL_ADDER_SUB_EN
  logic         ovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] h_sum;
  logic         h_cout;
  logic         h_ovf;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t vt[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
    .ovf       (ovf),
`endif
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic logic [W+1:0] model(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic ci,
                                         input logic s);
    int sx;
    int sy;
    int r;
    int u;
    logic [W-1:0] sm;
    logic co;
    logic ov;
    sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
    sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
    if (s) begin
      u  = (int'(x) - int'(y) + (1 << W)) % (1 << W);
      co = (x >= y);
      r  = sx - sy;
    end else begin
      u  = int'(x) + int'(y) + int'(ci);
      co = (u >= (1 << W));
      r  = sx + sy + int'(ci);
    end
    sm = W'(u);
    ov = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
    return {ov, co, sm};
  endfunction

  task automatic chk_res(input string nm,
                         input logic [W-1:0] es,
                         input logic ec,
                         input logic eo);
    chk({nm, "_sum"}, 32'(sum), 32'(es));
    chk({nm, "_cout"}, 32'(carry_out), 32'(ec));
`ifdef SERIAL_ADDER_SUB_EN
    chk({nm, "_ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo !== eo) $display("unreachable");
`endif
  endtask

  // Starts in the current cycle and returns in the done cycle.
  task automatic run_op(input logic [W-1:0] ta,
                        input logic [W-1:0] tb_,
                        input logic tc,
                        input logic ts,
                        input logic hold,
                        input logic [W-1:0] es,
                        input logic ec,
                        input logic eo);
    a = ta;
    b = tb_;
    carry_in = tc;
    sub = ts;
    start = 1'b1;
    tick();
    for (int k = 1; k <= W; k++) begin
      chk("busy_run", 32'(busy), 32'd1);
      chk("done_run", 32'(done), 32'd0);
      chk_res("hold", h_sum, h_cout, h_ovf);
      a = W'($urandom);
      b = W'($urandom);
      carry_in = 1'($urandom);
      sub = 1'($urandom);
      start = hold ? 1'b1 : 1'($urandom);
      tick();
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    chk_res("res", es, ec, eo);
    h_sum = es;
    h_cout = ec;
    h_ovf = eo;
  endtask

  task automatic idle_chk();
    start = 1'b0;
    tick();
    chk("done_idle", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [W+1:0] m;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rc;
    logic rs;

    vt.push_back('{8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0});
    vt.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
    vt.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0});
    vt.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    vt.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1});
    vt.push_back('{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1});
`ifdef SERIAL_ADDER_SUB_EN
    vt.push_back('{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0});
    vt.push_back('{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1});
`endif

    rst = 1'b1;
    start = 1'b1;
    a = 8'hAA;
    b = 8'h55;
    carry_in = 1'b1;
    sub = 1'b0;
    h_sum = '0;
    h_cout = 1'b0;
    h_ovf = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk_res("rst", '0, 1'b0, 1'b0);
    rst = 1'b0;
    idle_chk();

    foreach (vt[i]) begin
      run_op(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, 1'b0,
             vt[i].s, vt[i].co, vt[i].ov);
      idle_chk();
    end

    // Start held high: restarts every done cycle, busy presses ignored.
    for (int i = 0; i < 3; i++)
      run_op(8'h10, 8'h20, 1'b0, 1'b0, 1'b1, 8'h30, 1'b0, 1'b0);
    idle_chk();

    // Reset in RUN cycle 4, with start asserted alongside it.
    a = 8'h3C;
    b = 8'h05;
    carry_in = 1'b0;
    sub = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    h_sum = '0;
    h_cout = 1'b0;
    h_ovf = 1'b0;
    chk_res("abort", h_sum, h_cout, h_ovf);
    for (int k = 0; k < 12; k++) begin
      chk("abort_nodone", 32'(done), 32'd0);
      chk("abort_nobusy", 32'(busy), 32'd0);
      tick();
    end

    // Random operations, some issued back-to-back in the done cycle.
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      if (i % 7 == 0) rb = ~ra;
      m = model(ra, rb, rc, rs);
      run_op(ra, rb, rc, rs, 1'b0, m[W-1:0], m[W], m[W+1]);
      if ($urandom_range(0, 1) == 0) idle_chk();
    end
    idle_chk();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
